// File: rtl/mr1_mem_pkg.sv
// Shared types for the MR1 memory arbiter: request source tag and access sizes.
package mr1_mem_pkg;

    typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} mem_src_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mr1_src_fifo.sv
// In-order FIFO of source tags for reads in flight; the head names the owner of the next response.
module mr1_src_fifo
    import mr1_mem_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = mem_src_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_src,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               mem_q [DEPTH];
    T               mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_src;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mr1_mem_arbiter.sv
// Round-robin share of one memory port between MR1 fetch and load/store channels,
// with in-order routing of read responses back to the issuing channel.
module mr1_mem_arbiter
    import mr1_mem_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req_valid,
    output logic        instr_req_ready,
    input  logic [31:0] instr_req_addr,
    output logic        instr_rsp_valid,
    output logic [31:0] instr_rsp_data,
    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic        data_req_wr,
    input  logic [1:0]  data_req_size,
    input  logic [31:0] data_req_addr,
    input  logic [31:0] data_req_data,
    output logic        data_rsp_valid,
    output logic [31:0] data_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wr,
    output logic [1:0]  mem_req_size,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        rsp_orphan
);

    mem_src_t    sel, head;
    mem_src_t    last_grant_q, last_grant_d;
    mem_src_t    lock_src_q, lock_src_d;
    logic        lock_q, lock_d;
    logic        sel_valid, handshake, push, pop, full, empty;
    logic        instr_rsp_valid_q, instr_rsp_valid_d;
    logic        data_rsp_valid_q, data_rsp_valid_d;
    logic [31:0] instr_rsp_data_q, instr_rsp_data_d;
    logic [31:0] data_rsp_data_q, data_rsp_data_d;
    logic        orphan_q, orphan_d;

    // A stalled request keeps its source until the handshake, otherwise round-robin on ties.
    always_comb begin
        if (lock_q)
            sel = lock_src_q;
        else if (instr_req_valid && data_req_valid)
            sel = (last_grant_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        else if (data_req_valid)
            sel = SRC_DATA;
        else
            sel = SRC_INSTR;
    end

    assign sel_valid       = (sel == SRC_DATA) ? data_req_valid : instr_req_valid;
    assign mem_req_valid   = sel_valid && !full;
    assign mem_req_wr      = (sel == SRC_DATA) ? data_req_wr   : 1'b0;
    assign mem_req_size    = (sel == SRC_DATA) ? data_req_size : SIZE_W;
    assign mem_req_addr    = (sel == SRC_DATA) ? data_req_addr : instr_req_addr;
    assign mem_req_data    = (sel == SRC_DATA) ? data_req_data : 32'd0;
    assign handshake       = mem_req_valid && mem_req_ready;
    assign instr_req_ready = handshake && (sel == SRC_INSTR);
    assign data_req_ready  = handshake && (sel == SRC_DATA);
    assign push            = handshake && ((sel == SRC_INSTR) || !data_req_wr);
    assign pop             = mem_rsp_valid && !empty;

    mr1_src_fifo #(.DEPTH(OUTSTANDING), .T(mem_src_t)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_src (sel),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    always_comb begin
        last_grant_d      = last_grant_q;
        lock_d            = lock_q;
        lock_src_d        = lock_src_q;
        instr_rsp_valid_d = 1'b0;
        data_rsp_valid_d  = 1'b0;
        instr_rsp_data_d  = instr_rsp_data_q;
        data_rsp_data_d   = data_rsp_data_q;
        orphan_d          = orphan_q || (mem_rsp_valid && empty);
        if (handshake) begin
            last_grant_d = sel;
            lock_d       = 1'b0;
        end else if (mem_req_valid) begin
            lock_d     = 1'b1;
            lock_src_d = sel;
        end
        if (pop) begin
            if (head == SRC_INSTR) begin
                instr_rsp_valid_d = 1'b1;
                instr_rsp_data_d  = mem_rsp_data;
            end else begin
                data_rsp_valid_d = 1'b1;
                data_rsp_data_d  = mem_rsp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q      <= SRC_INSTR;
            lock_q            <= 1'b0;
            lock_src_q        <= SRC_INSTR;
            instr_rsp_valid_q <= 1'b0;
            data_rsp_valid_q  <= 1'b0;
            orphan_q          <= 1'b0;
        end else begin
            last_grant_q      <= last_grant_d;
            lock_q            <= lock_d;
            lock_src_q        <= lock_src_d;
            instr_rsp_valid_q <= instr_rsp_valid_d;
            data_rsp_valid_q  <= data_rsp_valid_d;
            orphan_q          <= orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        instr_rsp_data_q <= instr_rsp_data_d;
        data_rsp_data_q  <= data_rsp_data_d;
    end

    assign instr_rsp_valid = instr_rsp_valid_q;
    assign instr_rsp_data  = instr_rsp_data_q;
    assign data_rsp_valid  = data_rsp_valid_q;
    assign data_rsp_data   = data_rsp_data_q;
    assign rsp_orphan      = orphan_q;

endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// Directed bench for mr1_mem_arbiter: arbitration, backpressure, full FIFO, routing, orphan, reset.
module tb_mr1_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_req_valid = 1'b0, instr_req_ready;
    logic [31:0] instr_req_addr = '0;
    logic        instr_rsp_valid;
    logic [31:0] instr_rsp_data;
    logic        data_req_valid = 1'b0, data_req_ready;
    logic        data_req_wr = 1'b0;
    logic [1:0]  data_req_size = '0;
    logic [31:0] data_req_addr = '0, data_req_data = '0;
    logic        data_rsp_valid;
    logic [31:0] data_rsp_data;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_addr, mem_req_data;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        rsp_orphan;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mr1_mem_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset),
        .instr_req_valid(instr_req_valid), .instr_req_ready(instr_req_ready),
        .instr_req_addr(instr_req_addr), .instr_rsp_valid(instr_rsp_valid),
        .instr_rsp_data(instr_rsp_data),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_wr(data_req_wr), .data_req_size(data_req_size),
        .data_req_addr(data_req_addr), .data_req_data(data_req_data),
        .data_rsp_valid(data_rsp_valid), .data_rsp_data(data_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr(mem_req_wr), .mem_req_size(mem_req_size),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rsp_orphan(rsp_orphan)
    );

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req_valid = 1'b0; data_req_valid = 1'b0; data_req_wr = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({mem_req_valid, instr_req_ready, data_req_ready, instr_rsp_valid, data_rsp_valid, rsp_orphan} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", {mem_req_valid, instr_req_ready, data_req_ready, instr_rsp_valid, data_rsp_valid, rsp_orphan});
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        instr_req_valid = 1'b1; instr_req_addr = 32'h100; mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_wr, mem_req_size, instr_req_ready, data_req_ready} !== 6'b1_0_10_1_0 || mem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL fetch_req: got v/wr/sz/ir/dr=%b addr=%h expected 101010 addr=00000100", {mem_req_valid, mem_req_wr, mem_req_size, instr_req_ready, data_req_ready}, mem_req_addr);
        end
        step();
        instr_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (instr_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp_latency: instr_rsp_valid=%b expected 0", instr_rsp_valid);
        end
        step();
        mem_rsp_valid = 1'b0;
        checks++;
        if (instr_rsp_valid !== 1'b1 || instr_rsp_data !== 32'hDEADBEEF || data_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp: iv=%b data=%h dv=%b expected 1 deadbeef 0", instr_rsp_valid, instr_rsp_data, data_rsp_valid);
        end
        step();
        checks++;
        if (instr_rsp_valid !== 1'b0 || instr_rsp_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_rsp_pulse_hold: iv=%b data=%h expected 0 deadbeef", instr_rsp_valid, instr_rsp_data);
        end
    endtask

    task automatic test_tie();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h500; exp_addr[1] = 32'h400; exp_addr[2] = 32'h500;
        do_reset();
        instr_req_valid = 1'b1; instr_req_addr = 32'h400;
        data_req_valid = 1'b1; data_req_wr = 1'b1; data_req_size = 2'd2;
        data_req_addr = 32'h500; data_req_data = 32'h11;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_req_addr !== exp_addr[i] || data_req_ready !== (exp_addr[i] == 32'h500) || instr_req_ready !== (exp_addr[i] == 32'h400)) begin
                errors++;
                $display("FAIL tie_cycle%0d: addr=%h ir=%b dr=%b expected addr=%h", i, mem_req_addr, instr_req_ready, data_req_ready, exp_addr[i]);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        // A granted store first makes last_grant=DATA, so only the lock keeps data selected below.
        data_req_valid = 1'b1; data_req_wr = 1'b1; data_req_addr = 32'h2FC; mem_req_ready = 1'b1;
        step();
        data_req_wr = 1'b0; data_req_addr = 32'h200; mem_req_ready = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200 || data_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: v=%b addr=%h dr=%b expected 1 00000200 0", mem_req_valid, mem_req_addr, data_req_ready);
        end
        step();
        instr_req_valid = 1'b1; instr_req_addr = 32'h104;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (mem_req_addr !== 32'h200 || mem_req_wr !== 1'b0 || instr_req_ready !== 1'b0 || data_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: addr=%h wr=%b ir=%b dr=%b expected 00000200 0 0 0", i, mem_req_addr, mem_req_wr, instr_req_ready, data_req_ready);
            end
            step();
        end
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if (mem_req_addr !== 32'h200 || data_req_ready !== 1'b1 || instr_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: addr=%h dr=%b ir=%b expected 00000200 1 0", mem_req_addr, data_req_ready, instr_req_ready);
        end
        step();
        data_req_valid = 1'b0;
        #1;
        checks++;
        if (mem_req_addr !== 32'h104 || instr_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_instr: addr=%h ir=%b expected 00000104 1", mem_req_addr, instr_req_ready);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        mem_req_ready = 1'b1;
        instr_req_valid = 1'b1; instr_req_addr = 32'h10;
        step();
        instr_req_addr = 32'h14;
        step();
        instr_req_valid = 1'b0;
        data_req_valid = 1'b1; data_req_wr = 1'b0; data_req_addr = 32'h20;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || data_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_block: v=%b dr=%b expected 0 0", mem_req_valid, data_req_ready);
        end
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || data_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_same_cycle_pop: v=%b dr=%b expected 0 0", mem_req_valid, data_req_ready);
        end
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (instr_rsp_valid !== 1'b1 || instr_rsp_data !== 32'hA1 || mem_req_valid !== 1'b1 || data_req_ready !== 1'b1 || mem_req_addr !== 32'h20) begin
            errors++;
            $display("FAIL full_resume: iv=%b idata=%h v=%b dr=%b addr=%h expected 1 000000a1 1 1 00000020", instr_rsp_valid, instr_rsp_data, mem_req_valid, data_req_ready, mem_req_addr);
        end
        step();
        data_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA2;
        step();
        mem_rsp_data = 32'hA3;
        checks++;
        if (instr_rsp_valid !== 1'b1 || instr_rsp_data !== 32'hA2 || data_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_second: iv=%b idata=%h dv=%b expected 1 000000a2 0", instr_rsp_valid, instr_rsp_data, data_rsp_valid);
        end
        step();
        mem_rsp_valid = 1'b0;
        checks++;
        if (data_rsp_valid !== 1'b1 || data_rsp_data !== 32'hA3 || instr_rsp_valid !== 1'b0 || rsp_orphan !== 1'b0) begin
            errors++;
            $display("FAIL order_third: dv=%b ddata=%h iv=%b orphan=%b expected 1 000000a3 0 0", data_rsp_valid, data_rsp_data, instr_rsp_valid, rsp_orphan);
        end
        idle_inputs();
    endtask

    task automatic test_store_orphan();
        do_reset();
        data_req_valid = 1'b1; data_req_wr = 1'b1; data_req_size = 2'd0;
        data_req_addr = 32'h300; data_req_data = 32'h55; mem_req_ready = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_wr !== 1'b1 || mem_req_size !== 2'd0 || mem_req_addr !== 32'h300 || mem_req_data !== 32'h55) begin
            errors++;
            $display("FAIL store_req: v=%b wr=%b sz=%0d addr=%h data=%h expected 1 1 0 00000300 00000055", mem_req_valid, mem_req_wr, mem_req_size, mem_req_addr, mem_req_data);
        end
        step();
        data_req_valid = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77;
        step();
        mem_rsp_valid = 1'b0;
        checks++;
        if (rsp_orphan !== 1'b1 || instr_rsp_valid !== 1'b0 || data_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL orphan_set: orphan=%b iv=%b dv=%b expected 1 0 0", rsp_orphan, instr_rsp_valid, data_rsp_valid);
        end
        step();
        step();
        checks++;
        if (rsp_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky: orphan=%b expected 1", rsp_orphan);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        mem_req_ready = 1'b1;
        instr_req_valid = 1'b1; instr_req_addr = 32'h10;
        step();
        step();
        do_reset();
        #1;
        checks++;
        if ({mem_req_valid, instr_rsp_valid, data_rsp_valid, rsp_orphan} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 0000", {mem_req_valid, instr_rsp_valid, data_rsp_valid, rsp_orphan});
        end
        // With the FIFO cleared, a stale response must be reported as an orphan.
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        checks++;
        if (rsp_orphan !== 1'b1 || instr_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_fifo_cleared: orphan=%b iv=%b expected 1 0", rsp_orphan, instr_rsp_valid);
        end
        // Lock on instr, then reset: afterwards a tie must go to data.
        do_reset();
        data_req_valid = 1'b1; data_req_wr = 1'b1; mem_req_ready = 1'b1;
        step();
        data_req_valid = 1'b0; mem_req_ready = 1'b0;
        instr_req_valid = 1'b1; instr_req_addr = 32'h900;
        step();
        do_reset();
        instr_req_valid = 1'b1; instr_req_addr = 32'h900;
        data_req_valid = 1'b1; data_req_wr = 1'b1; data_req_addr = 32'h904; mem_req_ready = 1'b1;
        #1;
        checks++;
        if (mem_req_addr !== 32'h904 || data_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_lock_cleared: addr=%h dr=%b expected 00000904 1", mem_req_addr, data_req_ready);
        end
        step();
        data_req_valid = 1'b0;
        instr_req_addr = 32'h800;
        #1;
        checks++;
        if (mem_req_addr !== 32'h800 || instr_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL fresh_fetch_req: addr=%h ir=%b expected 00000800 1", mem_req_addr, instr_req_ready);
        end
        step();
        instr_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE0001;
        step();
        mem_rsp_valid = 1'b0;
        checks++;
        if (instr_rsp_valid !== 1'b1 || instr_rsp_data !== 32'hCAFE0001 || rsp_orphan !== 1'b0) begin
            errors++;
            $display("FAIL fresh_fetch_rsp: iv=%b data=%h orphan=%b expected 1 cafe0001 0", instr_rsp_valid, instr_rsp_data, rsp_orphan);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie();
        test_backpressure();
        test_full();
        test_store_orphan();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
